pea_firing_scheduler: RTL

//  Dataflow scheduler for the PEA actor: sits between the FIFO bank and the PEA top module.

---
 rtl/pea_firing_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pea_firing_scheduler.sv
// Dataflow firing scheduler for the PEA actor: gates invoke on FIFO population/space for the
// current mode, waits for firing-complete, flags hung firings and keeps firing/stall statistics.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | scheduling disabled, waiting for run
//   CHECK   | evaluating the enable condition for the registered mode
//   FIRE    | one-cycle invoke pulse to the actor
//   WAIT    | firing in progress, waiting for FC, watchdog counting
//   ERROR   | firing timed out; invoke held low until clr_err
module pea_firing_scheduler #(
  parameter  int word_size   = 16,
  parameter  int buffer_size = 1024,
  parameter  int TIMEOUT     = 4096,
  localparam int AW          = $clog2(buffer_size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          clr_err,
  input  logic [AW-1:0] command_pop,
  input  logic [AW-1:0] data_pop,
  input  logic [AW-1:0] result_free_space,
  input  logic [AW-1:0] status_free_space,
  input  logic [4:0]    req_count,
  input  logic          FC,
  input  logic [1:0]    next_mode_out,
  output logic          invoke,
  output logic [1:0]    next_mode_in,
  output logic          busy,
  output logic          timeout_err,
  output logic [15:0]   fire_count,
  output logic [15:0]   stall_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CW = (AW > 5) ? AW : 5;

  localparam logic [1:0] MODE_COMMAND = 2'b00;
  localparam logic [1:0] MODE_DATA    = 2'b01;
  localparam logic [1:0] MODE_RESULT  = 2'b10;
  localparam logic [1:0] MODE_STATUS  = 2'b11;

  if (word_size < 1) begin : g_word_size_check
    $error("word_size must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    mode;
  logic [TW-1:0] wait_cnt;
  logic          enable;
  logic          timeout_hit;
  logic          fc_accept;
  logic [CW-1:0] req_ext;
  logic [CW-1:0] data_ext;
  logic [CW-1:0] result_ext;

  assign req_ext     = CW'(req_count);
  assign data_ext    = CW'(data_pop);
  assign result_ext  = CW'(result_free_space);
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
  assign fc_accept   = (state == S_WAIT) && FC;

  always_comb begin
    enable = 1'b0;
    case (mode)
      MODE_COMMAND: enable = (command_pop != '0);
      MODE_DATA:    enable = (data_ext >= req_ext);
      MODE_RESULT:  enable = (result_ext >= req_ext) && (status_free_space != '0);
      MODE_STATUS:  enable = (status_free_space != '0);
      default:      enable = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_CHECK;
      S_CHECK: begin
        if (!run)        state_nxt = S_IDLE;
        else if (enable) state_nxt = S_FIRE;
      end
      S_FIRE:  state_nxt = S_WAIT;
      // FC in the same cycle as the watchdog expiring counts as a completed firing
      S_WAIT: begin
        if (FC)               state_nxt = run ? S_CHECK : S_IDLE;
        else if (timeout_hit) state_nxt = S_ERROR;
      end
      S_ERROR: if (clr_err) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    invoke = 1'b0;
    busy   = 1'b0;
    case (state)
      S_FIRE: begin
        invoke = 1'b1;
        busy   = 1'b1;
      end
      S_WAIT:  busy = 1'b1;
      default: begin
        invoke = 1'b0;
        busy   = 1'b0;
      end
    endcase
  end

  assign next_mode_in = mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_FIRE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      if (FC || timeout_hit) wait_cnt <= '0;
      else                   wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= MODE_COMMAND;
      fire_count <= '0;
    end else if (fc_accept) begin
      mode <= next_mode_out;
      if (fire_count != 16'hFFFF) fire_count <= fire_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if ((state == S_CHECK) && run && !enable && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if ((state == S_ERROR) && clr_err) begin
      timeout_err <= 1'b0;
    end else if ((state == S_WAIT) && !FC && timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

endmodule
